serial_frame_tx: RTL and testbench

//   Parallel-in / serial-out frame transmitter; the sending end of the team's single-wire serial link.

---
 rtl/serial_frame_tx.sv | 154 +++++++++++++++
 tb/tb_serial_frame_tx.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/serial_frame_tx.sv
// rtl/serial_frame_tx.sv - parallel-in/serial-out frame transmitter (start, data LSB first, [parity], stop)
// Optional even parity bit: define SERIAL_FRAME_TX_PARITY_EN
module serial_frame_tx #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              tx_out,
  output logic              tx_busy,
  output logic              tx_done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef SERIAL_FRAME_TX_PARITY_EN
    S_PARITY = 3'd4,
`endif
    S_STOP   = 3'd3
  } state_t;

  state_t            state, state_n;
  logic [CW-1:0]     cnt, cnt_n;
  logic [IW-1:0]     idx, idx_n;
  logic [DATA_W-1:0] shift_reg, shift_n;
  logic              out_n;
  logic              done_n;
  logic              last_tick;
  logic              last_bit;
`ifdef SERIAL_FRAME_TX_PARITY_EN
  logic              par, par_n;
`endif

  assign tx_ready  = (state == S_IDLE) && !reset;
  assign tx_busy   = (state != S_IDLE);
  assign last_tick = (cnt == CW'(CLKS_PER_BIT - 1));
  assign last_bit  = (idx == IW'(DATA_W - 1));

  // State and datapath registers; reset forces the line idle-high at once
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      idx       <= '0;
      shift_reg <= '0;
      tx_out    <= 1'b1;
      tx_done   <= 1'b0;
`ifdef SERIAL_FRAME_TX_PARITY_EN
      par       <= 1'b0;
`endif
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      idx       <= idx_n;
      shift_reg <= shift_n;
      tx_out    <= out_n;
      tx_done   <= done_n;
`ifdef SERIAL_FRAME_TX_PARITY_EN
      par       <= par_n;
`endif
    end
  end

  // Next state and next line value; the line value is chosen one cycle ahead so tx_out is a flop
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    shift_n = shift_reg;
    out_n   = tx_out;
    done_n  = 1'b0;
`ifdef SERIAL_FRAME_TX_PARITY_EN
    par_n   = par;
`endif
    case (state)
      S_IDLE: begin
        out_n = 1'b1;
        cnt_n = '0;
        idx_n = '0;
        if (tx_valid && tx_ready) begin
          shift_n = tx_data;
          out_n   = 1'b0;
          state_n = S_START;
`ifdef SERIAL_FRAME_TX_PARITY_EN
          par_n   = ^tx_data;
`endif
        end
      end
      S_START: begin
        if (last_tick) begin
          cnt_n   = '0;
          out_n   = shift_reg[0];
          state_n = S_DATA;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      S_DATA: begin
        if (last_tick) begin
          cnt_n = '0;
          if (last_bit) begin
`ifdef SERIAL_FRAME_TX_PARITY_EN
            out_n   = par;
            state_n = S_PARITY;
`else
            out_n   = 1'b1;
            state_n = S_STOP;
`endif
          end else begin
            idx_n   = idx + IW'(1);
            shift_n = shift_reg >> 1;
            out_n   = shift_n[0];
          end
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
`ifdef SERIAL_FRAME_TX_PARITY_EN
      S_PARITY: begin
        if (last_tick) begin
          cnt_n   = '0;
          out_n   = 1'b1;
          state_n = S_STOP;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
`endif
      S_STOP: begin
        if (last_tick) begin
          cnt_n   = '0;
          out_n   = 1'b1;
          done_n  = 1'b1;
          state_n = S_IDLE;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      default: begin
        state_n = S_IDLE;
        out_n   = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_serial_frame_tx.sv
// tb/tb_serial_frame_tx.sv - self-checking bench for serial_frame_tx against a timeline model
module tb_serial_frame_tx;

  localparam int DW  = 8;
  localparam int CPB = 4;
`ifdef SERIAL_FRAME_TX_PARITY_EN
  localparam int PB  = 1;
`else
  localparam int PB  = 0;
`endif
  localparam int NB  = DW + 2 + PB;
  localparam int F   = NB * CPB;
  localparam int NB1 = 4 + 2 + PB;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [DW-1:0] tx_data = '0;
  logic          tx_valid = 1'b0;
  logic          tx_ready, tx_out, tx_busy, tx_done;

  logic          c_reset = 1'b1;
  logic [3:0]    c_data = '0;
  logic          c_valid = 1'b0;
  logic          c_ready, c_out, c_busy, c_done;

  int checks = 0;
  int errors = 0;

  bit   m_active = 0;
  bit   m_done = 0;
  int   m_k = 0;
  logic m_bits[NB];

  int   e1[$];

  serial_frame_tx #(.DATA_W(DW), .CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx_out(tx_out), .tx_busy(tx_busy), .tx_done(tx_done)
  );

  serial_frame_tx #(.DATA_W(4), .CLKS_PER_BIT(1)) dut1 (
    .clk(clk), .reset(c_reset), .tx_data(c_data), .tx_valid(c_valid),
    .tx_ready(c_ready), .tx_out(c_out), .tx_busy(c_busy), .tx_done(c_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock of the main DUT: the model sees the frame as a timeline measured from the acceptance edge
  task automatic step();
    logic [DW-1:0] d;
    bit acc;
    logic exp_out;
    d   = tx_data;
    acc = tx_valid && !m_active && !reset;
    @(posedge clk);
    m_done = 0;
    if (reset) begin
      m_active = 0;
    end else if (acc) begin
      m_active = 1;
      m_k = 0;
      m_bits[0] = 1'b0;
      for (int i = 0; i < DW; i++) m_bits[1+i] = d[i];
`ifdef SERIAL_FRAME_TX_PARITY_EN
      m_bits[DW+1] = ^d;
`endif
      m_bits[NB-1] = 1'b1;
    end else if (m_active) begin
      m_k++;
      if (m_k == F) begin
        m_active = 0;
        m_done = 1;
      end
    end
    #1;
    exp_out = m_active ? m_bits[m_k / CPB] : 1'b1;
    check("tx_out",   32'(tx_out),   32'(exp_out));
    check("tx_busy",  32'(tx_busy),  32'(m_active));
    check("tx_done",  32'(tx_done),  32'(m_done));
    check("tx_ready", 32'(tx_ready), 32'(!m_active && !reset));
  endtask

  initial begin
    // reset held two cycles
    step();
    step();
    reset = 1'b0;
    step();

    // single word A5
    tx_data = 8'hA5; tx_valid = 1'b1;
    step();
    tx_valid = 1'b0;
    repeat (F + 3) step();

    // data changed mid-frame with valid held: first frame intact, second follows done
    tx_data = 8'h3C; tx_valid = 1'b1;
    step();
    tx_data = 8'hFF;
    repeat (F + 2) step();
    tx_valid = 1'b0;
    repeat (F + 3) step();

    // continuous valid: 00 then FF back-to-back
    tx_data = 8'h00; tx_valid = 1'b1;
    step();
    tx_data = 8'hFF;
    repeat (F + 2) step();
    tx_valid = 1'b0;
    repeat (F + 3) step();

    // reset during data bit 3 of 55
    tx_data = 8'h55; tx_valid = 1'b1;
    step();
    tx_valid = 1'b0;
    repeat (4 * CPB + 1) step();
    check("mid_bit3_index", 32'(m_k / CPB), 32'd4);
    #3;
    reset = 1'b1;
    #1;
    m_active = 0;
    check("abort_tx_out",   32'(tx_out),   32'd1);
    check("abort_tx_busy",  32'(tx_busy),  32'd0);
    check("abort_tx_ready", 32'(tx_ready), 32'd0);
    check("abort_tx_done",  32'(tx_done),  32'd0);
    step();
    step();
    reset = 1'b0;
    step();
    tx_data = 8'h55; tx_valid = 1'b1;
    step();
    tx_valid = 1'b0;
    repeat (F + 3) step();

    // random producer: valid and data wander every cycle
    for (int n = 0; n < 600; n++) begin
      tx_valid = ($urandom_range(0, 3) != 0);
      tx_data  = DW'($urandom);
      step();
    end
    tx_valid = 1'b0;
    repeat (F + 3) step();

    // narrow instance: DATA_W=4, CLKS_PER_BIT=1, word 9
`ifdef SERIAL_FRAME_TX_PARITY_EN
    e1 = '{0, 1, 0, 0, 1, 0, 1};
`else
    e1 = '{0, 1, 0, 0, 1, 1};
`endif
    @(posedge clk);
    #1;
    check("c_reset_ready", 32'(c_ready), 32'd0);
    check("c_reset_out",   32'(c_out),   32'd1);
    c_reset = 1'b0;
    c_data  = 4'h9;
    c_valid = 1'b1;
    #1;
    check("c_idle_ready", 32'(c_ready), 32'd1);
    @(posedge clk);
    #1;
    c_valid = 1'b0;
    for (int k = 0; k < NB1; k++) begin
      check("c_out",  32'(c_out),  32'(e1[k]));
      check("c_busy", 32'(c_busy), 32'd1);
      check("c_done", 32'(c_done), 32'd0);
      @(posedge clk);
      #1;
    end
    check("c_end_out",   32'(c_out),   32'd1);
    check("c_end_busy",  32'(c_busy),  32'd0);
    check("c_end_done",  32'(c_done),  32'd1);
    check("c_end_ready", 32'(c_ready), 32'd1);
    @(posedge clk);
    #1;
    check("c_done_once", 32'(c_done), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
